boot_sequencer: RTL and testbench

//  Hardware bring-up controller for the pulpino_top core. Sequence on start: hold core reset,

---
 rtl/boot_seq_pkg.sv | 40 ++++
 rtl/boot_seq_apb_master.sv | 82 ++++++++
 rtl/boot_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_boot_sequencer.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/boot_seq_pkg.sv
// Shared types for the pulpino boot sequencer.
// FSM states, error codes and APB master phases.
package boot_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RST_HOLD,
    ST_SETTLE,
    ST_CFG_SETUP,
    ST_CFG_ACCESS,
    ST_LOAD,
    ST_FETCH_WAIT,
    ST_RUN,
    ST_STAT_SETUP,
    ST_STAT_ACCESS,
    ST_DONE,
    ST_ERROR
  } boot_state_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_SLVERR  = 2'd1,
    ERR_APB_TO  = 2'd2,
    ERR_LOAD_TO = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS
  } apb_phase_e;

  function automatic int unsigned max2(
    input int unsigned a,
    input int unsigned b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/boot_seq_apb_master.sv
// Single-transfer APB master shared by the config write and status read.
// The wait-state timeout comes from the sequencer's shared counter.
module boot_seq_apb_master
  import boot_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        cnt_zero_i,
  output logic        done_o,
  output logic        err_o,
  output logic        timeout_o,
  output logic [31:0] rdata_o,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic        pwrite_o,
  output logic        psel_o,
  output logic        penable_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i
);

  apb_phase_e  phase_q, phase_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        access;

  assign access = (phase_q == APB_ACCESS);

  always_comb begin
    phase_d = phase_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (phase_q)
      APB_IDLE: begin
        if (req_i) begin
          phase_d = APB_SETUP;
          we_d    = we_i;
          addr_d  = addr_i;
          wdata_d = wdata_i;
        end
      end
      APB_SETUP: phase_d = APB_ACCESS;
      APB_ACCESS: begin
        if (pready_i || cnt_zero_i) phase_d = APB_IDLE;
      end
      default: phase_d = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= APB_IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      phase_q <= phase_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign done_o    = access && pready_i && !pslverr_i;
  assign err_o     = access && pready_i && pslverr_i;
  assign timeout_o = access && !pready_i && cnt_zero_i;
  assign rdata_o   = prdata_i;

  assign psel_o    = (phase_q != APB_IDLE);
  assign penable_o = access;
  assign pwrite_o  = psel_o && we_q;
  assign paddr_o   = addr_q;
  assign pwdata_o  = wdata_q;

endmodule

// File: rtl/boot_sequencer.sv
// Core bring-up controller: reset, boot-address write, optional L2 load,
// fetch enable, then wait for end-of-computation and read the exit code.
module boot_sequencer
  import boot_seq_pkg::*;
#(
  parameter int unsigned RST_CYCLES     = 16,
  parameter int unsigned SETTLE_CYCLES  = 25,
  parameter int unsigned FETCH_DELAY    = 5,
  parameter logic [31:0] BOOT_REG_ADDR  = 32'h1A10_7008,
  parameter logic [31:0] STATUS_ADDR    = 32'h1A10_7018,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        skip_load_i,
  input  logic [31:0] boot_addr_i,
  output logic [31:0] paddr_o,
  output logic [31:0] pwdata_o,
  output logic        pwrite_o,
  output logic        psel_o,
  output logic        penable_o,
  input  logic [31:0] prdata_i,
  input  logic        pready_i,
  input  logic        pslverr_i,
  output logic        load_req_o,
  input  logic        load_done_i,
  output logic        core_rst_n_o,
  output logic        fetch_enable_o,
  input  logic        eoc_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [1:0]  err_code_o,
  output logic [31:0] exit_code_o
);

  localparam int unsigned MAXP =
    max2(max2(RST_CYCLES, SETTLE_CYCLES),
         max2(FETCH_DELAY, TIMEOUT_CYCLES));
  localparam int unsigned CW = $clog2(MAXP) + 1;

  boot_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          cnt_zero;
  logic          done_q, done_d;
  logic          error_q, error_d;
  err_code_e     err_q, err_d;
  logic [31:0]   exit_q, exit_d;
  logic [31:0]   boot_q, boot_d;
  logic          skip_q, skip_d;
  logic          start_q, start_rise;
  logic          eoc_s1_q, eoc_s2_q;

  logic          apb_req, apb_we;
  logic [31:0]   apb_addr, apb_wdata, apb_rdata;
  logic          apb_done, apb_err, apb_to;

  assign cnt_zero   = (cnt_q == '0);
  assign start_rise = start_i && !start_q;

  boot_seq_apb_master u_apb (
    .clk        (clk),
    .rst        (rst),
    .req_i      (apb_req),
    .we_i       (apb_we),
    .addr_i     (apb_addr),
    .wdata_i    (apb_wdata),
    .cnt_zero_i (cnt_zero),
    .done_o     (apb_done),
    .err_o      (apb_err),
    .timeout_o  (apb_to),
    .rdata_o    (apb_rdata),
    .paddr_o    (paddr_o),
    .pwdata_o   (pwdata_o),
    .pwrite_o   (pwrite_o),
    .psel_o     (psel_o),
    .penable_o  (penable_o),
    .prdata_i   (prdata_i),
    .pready_i   (pready_i),
    .pslverr_i  (pslverr_i)
  );

  always_comb begin
    state_d   = state_q;
    done_d    = done_q;
    error_d   = error_q;
    err_d     = err_q;
    exit_d    = exit_q;
    boot_d    = boot_q;
    skip_d    = skip_q;
    apb_req   = 1'b0;
    apb_we    = 1'b0;
    apb_addr  = BOOT_REG_ADDR;
    apb_wdata = boot_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start_rise) begin
          state_d = ST_RST_HOLD;
          done_d  = 1'b0;
          error_d = 1'b0;
          err_d   = ERR_NONE;
          exit_d  = '0;
          boot_d  = boot_addr_i;
          skip_d  = skip_load_i;
        end
      end
      ST_RST_HOLD: if (cnt_zero) state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (cnt_zero) begin
          state_d = ST_CFG_SETUP;
          apb_req = 1'b1;
          apb_we  = 1'b1;
        end
      end
      ST_CFG_SETUP: state_d = ST_CFG_ACCESS;
      ST_CFG_ACCESS: begin
        if (apb_done) begin
          state_d = skip_q ? ST_FETCH_WAIT : ST_LOAD;
        end else if (apb_err) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          err_d   = ERR_SLVERR;
        end else if (apb_to) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          err_d   = ERR_APB_TO;
        end
      end
      ST_LOAD: begin
        if (load_done_i) begin
          state_d = ST_FETCH_WAIT;
        end else if (cnt_zero) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          err_d   = ERR_LOAD_TO;
        end
      end
      ST_FETCH_WAIT: if (cnt_zero) state_d = ST_RUN;
      ST_RUN: begin
        if (eoc_s2_q) begin
          state_d   = ST_STAT_SETUP;
          apb_req   = 1'b1;
          apb_addr  = STATUS_ADDR;
          apb_wdata = '0;
        end
      end
      ST_STAT_SETUP: state_d = ST_STAT_ACCESS;
      ST_STAT_ACCESS: begin
        if (apb_done) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          exit_d  = apb_rdata;
        end else if (apb_err) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          err_d   = ERR_SLVERR;
        end else if (apb_to) begin
          state_d = ST_ERROR;
          error_d = 1'b1;
          err_d   = ERR_APB_TO;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Reload on every state entry so each state sees a full N-cycle window.
  always_comb begin
    cnt_d = cnt_zero ? cnt_q : cnt_q - CW'(1);
    if (state_d != state_q) begin
      unique case (state_d)
        ST_RST_HOLD:    cnt_d = CW'(RST_CYCLES - 1);
        ST_SETTLE:      cnt_d = CW'(SETTLE_CYCLES - 1);
        ST_CFG_ACCESS:  cnt_d = CW'(TIMEOUT_CYCLES - 1);
        ST_LOAD:        cnt_d = CW'(TIMEOUT_CYCLES - 1);
        ST_STAT_ACCESS: cnt_d = CW'(TIMEOUT_CYCLES - 1);
        ST_FETCH_WAIT:  cnt_d = CW'(FETCH_DELAY - 1);
        default:        cnt_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      err_q    <= ERR_NONE;
      exit_q   <= '0;
      boot_q   <= '0;
      skip_q   <= 1'b0;
      start_q  <= 1'b0;
      eoc_s1_q <= 1'b0;
      eoc_s2_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
      error_q  <= error_d;
      err_q    <= err_d;
      exit_q   <= exit_d;
      boot_q   <= boot_d;
      skip_q   <= skip_d;
      start_q  <= start_i;
      eoc_s1_q <= eoc_i;
      eoc_s2_q <= eoc_s1_q;
    end
  end

  assign busy_o = !(state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign core_rst_n_o =
    !(state_q inside {ST_IDLE, ST_RST_HOLD, ST_ERROR});
  assign fetch_enable_o =
    state_q inside {ST_RUN, ST_STAT_SETUP, ST_STAT_ACCESS, ST_DONE};
  assign load_req_o  = (state_q == ST_LOAD);
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign err_code_o  = err_q;
  assign exit_code_o = exit_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Scenario bench for boot_sequencer: APB slave model plus
// scoreboard queues of expected bus transfers and exit codes.
module tb_boot_sequencer;

  localparam int RST_C    = 16;
  localparam int SETTLE_C = 25;
  localparam int FETCH_C  = 5;
  localparam int TO_C     = 1024;
  localparam logic [31:0] BOOT_A = 32'h1A10_7008;
  localparam logic [31:0] STAT_A = 32'h1A10_7018;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } apb_t;

  logic        clk, rst, start_i, skip_load_i;
  logic [31:0] boot_addr_i, paddr_o, pwdata_o, prdata_i;
  logic        pwrite_o, psel_o, penable_o, pready_i, pslverr_i;
  logic        load_req_o, load_done_i, core_rst_n_o;
  logic        fetch_enable_o, eoc_i, busy_o, done_o, error_o;
  logic [1:0]  err_code_o;
  logic [31:0] exit_code_o;

  apb_t        apb_q[$];
  logic [31:0] res_q[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          slv_wait = 0;
  bit          slv_err = 0;
  logic [31:0] slv_rdata = '0;
  int          acc_cnt = 0;
  bit          fetch_seen = 0;
  bit          load_seen = 0;

  boot_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .skip_load_i    (skip_load_i),
    .boot_addr_i    (boot_addr_i),
    .paddr_o        (paddr_o),
    .pwdata_o       (pwdata_o),
    .pwrite_o       (pwrite_o),
    .psel_o         (psel_o),
    .penable_o      (penable_o),
    .prdata_i       (prdata_i),
    .pready_i       (pready_i),
    .pslverr_i      (pslverr_i),
    .load_req_o     (load_req_o),
    .load_done_i    (load_done_i),
    .core_rst_n_o   (core_rst_n_o),
    .fetch_enable_o (fetch_enable_o),
    .eoc_i          (eoc_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .error_o        (error_o),
    .err_code_o     (err_code_o),
    .exit_code_o    (exit_code_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign prdata_i = slv_rdata;

  // APB slave: pready after slv_wait access cycles; also flag observers.
  always @(posedge clk) begin
    #1;
    if (psel_o && penable_o) begin
      pready_i  = (acc_cnt >= slv_wait);
      pslverr_i = slv_err && (acc_cnt >= slv_wait);
      acc_cnt++;
    end else begin
      pready_i  = 1'b0;
      pslverr_i = 1'b0;
      acc_cnt   = 0;
    end
    if (fetch_enable_o) fetch_seen = 1;
    if (load_req_o) load_seen = 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clk) start_i = 1'b1;
    @(negedge clk) start_i = 1'b0;
  endtask

  task automatic wait_apb(input int budget, output apb_t obs,
                          output bit to);
    to  = 1;
    obs = '0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (psel_o && penable_o && pready_i) begin
        obs = '{paddr_o, pwrite_o, pwdata_o};
        to  = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [106:0] outs;
    repeat (3) @(negedge clk);
    outs = {paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
            load_req_o, core_rst_n_o, fetch_enable_o, busy_o,
            done_o, error_o, err_code_o, exit_code_o};
    vectors++;
    if (outs !== '0) begin
      miscompares++;
      $display("FAIL reset_outs: got %h, expected 0", outs);
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy_o !== 0 || core_rst_n_o !== 0 || psel_o !== 0) begin
      miscompares++;
      $display("FAIL idle_after_reset: busy=%b rst_n=%b psel=%b, expected 0 0 0",
               busy_o, core_rst_n_o, psel_o);
    end
  endtask

  task automatic test_standalone();
    apb_t obs, exp;
    bit to;
    int n;
    skip_load_i = 1; boot_addr_i = '0; slv_wait = 2; slv_err = 0;
    slv_rdata = '0; eoc_i = 0; load_done_i = 0;
    exp = '{BOOT_A, 1'b1, 32'h0}; apb_q.push_back(exp);
    exp = '{STAT_A, 1'b0, 32'h0}; apb_q.push_back(exp);
    res_q.push_back(32'h0);
    pulse_start();
    load_seen = 0;
    vectors++;
    if (busy_o !== 1 || core_rst_n_o !== 0) begin
      miscompares++;
      $display("FAIL start_busy: busy=%b rst_n=%b, expected 1 0",
               busy_o, core_rst_n_o);
    end
    n = 0;
    while (core_rst_n_o !== 1 && n < 200) begin n++; @(negedge clk); end
    vectors++;
    if (n !== RST_C) begin
      miscompares++;
      $display("FAIL rst_hold: got %0d cycles, expected %0d", n, RST_C);
    end
    n = 0;
    while (psel_o !== 1 && n < 200) begin n++; @(negedge clk); end
    vectors++;
    if (n !== SETTLE_C) begin
      miscompares++;
      $display("FAIL settle: got %0d cycles, expected %0d", n, SETTLE_C);
    end
    vectors++;
    if (penable_o !== 0 || pwrite_o !== 1 || paddr_o !== BOOT_A) begin
      miscompares++;
      $display("FAIL cfg_setup: penable=%b pwrite=%b paddr=%h, expected 0 1 %h",
               penable_o, pwrite_o, paddr_o, BOOT_A);
    end
    wait_apb(TO_C + 10, obs, to);
    exp = apb_q.pop_front();
    vectors++;
    if (to || obs !== exp) begin
      miscompares++;
      $display("FAIL cfg_write: got %h timeout=%0d, expected %h", obs, to, exp);
    end
    @(negedge clk);
    vectors++;
    if (psel_o !== 0 || penable_o !== 0) begin
      miscompares++;
      $display("FAIL apb_release: psel=%b penable=%b, expected 0 0",
               psel_o, penable_o);
    end
    n = 1;
    while (fetch_enable_o !== 1 && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (n !== FETCH_C + 1 || load_seen) begin
      miscompares++;
      $display("FAIL fetch_delay: got %0d cycles load_seen=%0d, expected %0d 0",
               n, load_seen, FETCH_C + 1);
    end
    repeat (200) @(negedge clk);
    eoc_i = 1;
    wait_apb(TO_C + 20, obs, to);
    exp = apb_q.pop_front();
    vectors++;
    if (to || obs.addr !== exp.addr || obs.we !== exp.we) begin
      miscompares++;
      $display("FAIL stat_read: got %h/%b timeout=%0d, expected %h/%b",
               obs.addr, obs.we, to, exp.addr, exp.we);
    end
    n = 0;
    while (busy_o === 1 && n < 50) begin n++; @(negedge clk); end
    vectors++;
    if (done_o !== 1 || error_o !== 0 || exit_code_o !== res_q.pop_front()
        || fetch_enable_o !== 1 || core_rst_n_o !== 1) begin
      miscompares++;
      $display("FAIL t1_done: done=%b err=%b exit=%h fe=%b rst_n=%b, expected 1 0 0 1 1",
               done_o, error_o, exit_code_o, fetch_enable_o, core_rst_n_o);
    end
    eoc_i = 0;
  endtask

  task automatic test_loader();
    apb_t obs, exp;
    bit to;
    int n, c;
    skip_load_i = 0; boot_addr_i = 32'h0000_8000; slv_wait = 0;
    slv_rdata = 32'h1;
    exp = '{BOOT_A, 1'b1, 32'h0000_8000}; apb_q.push_back(exp);
    exp = '{STAT_A, 1'b0, 32'h0}; apb_q.push_back(exp);
    res_q.push_back(32'h1);
    pulse_start();
    fetch_seen = 0;
    wait_apb(200, obs, to);
    exp = apb_q.pop_front();
    vectors++;
    if (to || obs !== exp) begin
      miscompares++;
      $display("FAIL load_cfg_write: got %h timeout=%0d, expected %h", obs, to, exp);
    end
    @(negedge clk);
    c = 0;
    while (load_req_o === 1 && c < 200) begin
      c++;
      if (c == 50) load_done_i = 1;
      @(negedge clk);
      load_done_i = 0;
    end
    vectors++;
    if (c !== 50 || fetch_seen) begin
      miscompares++;
      $display("FAIL load_req_len: got %0d cycles fetch_seen=%0d, expected 50 0",
               c, fetch_seen);
    end
    n = 1;
    while (fetch_enable_o !== 1 && n < 200) begin @(negedge clk); n++; end
    vectors++;
    if (n !== FETCH_C + 1) begin
      miscompares++;
      $display("FAIL load_fetch_delay: got %0d, expected %0d", n, FETCH_C + 1);
    end
    eoc_i = 1;
    wait_apb(TO_C + 20, obs, to);
    exp = apb_q.pop_front();
    vectors++;
    if (to || obs.addr !== exp.addr || obs.we !== exp.we) begin
      miscompares++;
      $display("FAIL load_stat_read: got %h/%b timeout=%0d, expected %h/%b",
               obs.addr, obs.we, to, exp.addr, exp.we);
    end
    n = 0;
    while (busy_o === 1 && n < 50) begin n++; @(negedge clk); end
    vectors++;
    if (done_o !== 1 || exit_code_o !== res_q.pop_front()) begin
      miscompares++;
      $display("FAIL t2_done: done=%b exit=%h, expected 1 00000001",
               done_o, exit_code_o);
    end
    eoc_i = 0;
  endtask

  task automatic test_slverr();
    apb_t obs, exp;
    bit to;
    skip_load_i = 1; boot_addr_i = 32'h1234_5678; slv_wait = 1;
    slv_err = 1;
    exp = '{BOOT_A, 1'b1, 32'h1234_5678}; apb_q.push_back(exp);
    pulse_start();
    fetch_seen = 0;
    wait_apb(200, obs, to);
    exp = apb_q.pop_front();
    vectors++;
    if (to || obs !== exp) begin
      miscompares++;
      $display("FAIL slverr_write: got %h timeout=%0d, expected %h", obs, to, exp);
    end
    @(negedge clk);
    vectors++;
    if (error_o !== 1 || err_code_o !== 2'd1 || busy_o !== 0 || done_o !== 0
        || fetch_seen || core_rst_n_o !== 0 || psel_o !== 0) begin
      miscompares++;
      $display("FAIL slverr: err=%b code=%0d busy=%b done=%b fe_seen=%0d rst_n=%b psel=%b, expected 1 1 0 0 0 0 0",
               error_o, err_code_o, busy_o, done_o, fetch_seen,
               core_rst_n_o, psel_o);
    end
    slv_err = 0;
  endtask

  task automatic test_timeouts();
    int n, k;
    skip_load_i = 1; slv_wait = 1_000_000;
    pulse_start();
    n = 0; k = 0;
    while (error_o !== 1 && k < 3000) begin
      if (penable_o === 1) n++;
      k++;
      @(negedge clk);
    end
    vectors++;
    if (n !== TO_C || err_code_o !== 2'd2 || psel_o !== 0) begin
      miscompares++;
      $display("FAIL apb_timeout: access=%0d code=%0d psel=%b, expected %0d 2 0",
               n, err_code_o, psel_o, TO_C);
    end
    skip_load_i = 0; slv_wait = 0; load_done_i = 0;
    pulse_start();
    n = 0; k = 0;
    while (error_o !== 1 && k < 3000) begin
      if (load_req_o === 1) n++;
      k++;
      @(negedge clk);
    end
    vectors++;
    if (n !== TO_C || err_code_o !== 2'd3 || load_req_o !== 0) begin
      miscompares++;
      $display("FAIL load_timeout: load=%0d code=%0d req=%b, expected %0d 3 0",
               n, err_code_o, load_req_o, TO_C);
    end
  endtask

  task automatic test_rst_midflight();
    logic [106:0] outs;
    int k;
    skip_load_i = 1; slv_wait = 1_000_000;
    pulse_start();
    k = 0;
    while (penable_o !== 1 && k < 200) begin k++; @(negedge clk); end
    rst = 1'b1;
    #1;
    outs = {paddr_o, pwdata_o, pwrite_o, psel_o, penable_o,
            load_req_o, core_rst_n_o, fetch_enable_o, busy_o,
            done_o, error_o, err_code_o, exit_code_o};
    vectors++;
    if (k >= 200 || outs !== '0) begin
      miscompares++;
      $display("FAIL rst_midflight: got %h reached_access=%0d, expected 0",
               outs, k < 200);
    end
    @(negedge clk);
    rst = 1'b0;
    slv_wait = 2;
  endtask

  task automatic test_back_to_back();
    apb_t obs, exp;
    bit to;
    int n;
    skip_load_i = 1; boot_addr_i = 32'h0000_00A5;
    slv_rdata = 32'hDEAD_BEEF;
    exp = '{BOOT_A, 1'b1, 32'h0000_00A5}; apb_q.push_back(exp);
    res_q.push_back(32'hDEAD_BEEF);
    pulse_start();
    wait_apb(200, obs, to);
    exp = apb_q.pop_front();
    vectors++;
    if (to || obs !== exp) begin
      miscompares++;
      $display("FAIL b2b_cfg: got %h timeout=%0d, expected %h", obs, to, exp);
    end
    n = 0;
    while (fetch_enable_o !== 1 && n < 200) begin @(negedge clk); n++; end
    pulse_start();
    repeat (3) @(negedge clk);
    vectors++;
    if (busy_o !== 1 || core_rst_n_o !== 1 || fetch_enable_o !== 1) begin
      miscompares++;
      $display("FAIL start_in_run: busy=%b rst_n=%b fe=%b, expected 1 1 1",
               busy_o, core_rst_n_o, fetch_enable_o);
    end
    eoc_i = 1;
    n = 0;
    while (busy_o === 1 && n < TO_C) begin n++; @(negedge clk); end
    vectors++;
    if (done_o !== 1 || exit_code_o !== res_q.pop_front()) begin
      miscompares++;
      $display("FAIL b2b_first: done=%b exit=%h, expected 1 deadbeef",
               done_o, exit_code_o);
    end
    eoc_i = 0;
    slv_rdata = 32'h0000_0055;
    exp = '{STAT_A, 1'b0, 32'h0}; apb_q.push_back(exp);
    res_q.push_back(32'h0000_0055);
    pulse_start();
    vectors++;
    if (exit_code_o !== 0 || done_o !== 0 || busy_o !== 1
        || fetch_enable_o !== 0) begin
      miscompares++;
      $display("FAIL restart_clear: exit=%h done=%b busy=%b fe=%b, expected 0 0 1 0",
               exit_code_o, done_o, busy_o, fetch_enable_o);
    end
    n = 0;
    while (core_rst_n_o !== 1 && n < 200) begin n++; @(negedge clk); end
    vectors++;
    if (n !== RST_C) begin
      miscompares++;
      $display("FAIL restart_rst_hold: got %0d, expected %0d", n, RST_C);
    end
    wait_apb(200, obs, to);
    eoc_i = 1;
    wait_apb(200, obs, to);
    exp = apb_q.pop_front();
    vectors++;
    if (to || obs.addr !== exp.addr || obs.we !== exp.we) begin
      miscompares++;
      $display("FAIL restart_stat: got %h/%b timeout=%0d, expected %h/%b",
               obs.addr, obs.we, to, exp.addr, exp.we);
    end
    n = 0;
    while (busy_o === 1 && n < 50) begin n++; @(negedge clk); end
    vectors++;
    if (done_o !== 1 || exit_code_o !== res_q.pop_front()) begin
      miscompares++;
      $display("FAIL restart_done: done=%b exit=%h, expected 1 00000055",
               done_o, exit_code_o);
    end
    eoc_i = 0;
  endtask

  task automatic test_eoc_early();
    apb_t obs;
    bit to;
    int n, r;
    skip_load_i = 1; slv_wait = 0; slv_rdata = 32'h7;
    res_q.push_back(32'h7);
    eoc_i = 1;
    pulse_start();
    wait_apb(200, obs, to);
    n = 0;
    while (fetch_enable_o !== 1 && n < 200) begin @(negedge clk); n++; end
    r = 0;
    while (psel_o !== 1 && r < 10) begin @(negedge clk); r++; end
    vectors++;
    if (r < 1 || r > 3 || paddr_o !== STAT_A) begin
      miscompares++;
      $display("FAIL eoc_early: status read after %0d cycles addr=%h, expected 1..3 %h",
               r, paddr_o, STAT_A);
    end
    n = 0;
    while (busy_o === 1 && n < 50) begin n++; @(negedge clk); end
    vectors++;
    if (done_o !== 1 || exit_code_o !== res_q.pop_front()) begin
      miscompares++;
      $display("FAIL eoc_early_done: done=%b exit=%h, expected 1 00000007",
               done_o, exit_code_o);
    end
    eoc_i = 0;
  endtask

  initial begin
    rst = 1'b1; start_i = 0; skip_load_i = 0; boot_addr_i = '0;
    load_done_i = 0; eoc_i = 0; pready_i = 0; pslverr_i = 0;
    test_reset();
    test_standalone();
    test_loader();
    test_slverr();
    test_timeouts();
    test_rst_midflight();
    test_back_to_back();
    test_eoc_early();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
